// File: rtl/ped_crossing_ctrl_pkg.sv
// rtl/ped_crossing_ctrl_pkg.sv - lamp encodings and pedestrian FSM state encoding
package ped_crossing_ctrl_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WALK  = 2'd1;
    localparam logic [1:0] ST_FLASH = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_WALK  = ST_WALK,
        S_FLASH = ST_FLASH
    } ped_state_e;

    // LAMP_OFF is not one-hot, so a dark head counts as illegal too
    function automatic logic lamp_one_hot(input logic [2:0] lamp);
        return (lamp == LAMP_RED) || (lamp == LAMP_YEL) || (lamp == LAMP_GRN);
    endfunction

endpackage

// File: rtl/ped_crossing_ctrl_btn_debounce.sv
// rtl/ped_crossing_ctrl_btn_debounce.sv - push-button synchronizer, debounce and rising-edge pulse
module ped_crossing_ctrl_btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // rise is taken from the next level so the request latches on the accepting edge
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise = level_d & ~level_q;
    end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - pedestrian WALK/DON'T-WALK controller for the road-1 crossing
// Optional countdown register enabled by macro PED_COUNTDOWN_EN.
module ped_crossing_ctrl
    import ped_crossing_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int WALK_SEC     = 7,
    parameter int FLASH_SEC    = 5,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [2:0]       light_1,
    input  logic [2:0]       light_2,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);

    ped_state_e       state_q, state_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic             req_q, req_d;
    logic             fault_q, fault_d;
    logic             flash_dw_q, flash_dw_d;
    logic             btn_rise, ped_red, conflict, grant;

    ped_crossing_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (ped_btn),
        .rise    (btn_rise)
    );

    assign ped_red  = (light_1 == LAMP_RED);
    assign conflict = (light_1[0] & light_2[0]) | ~lamp_one_hot(light_1) | ~lamp_one_hot(light_2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sec_q      <= '0;
            req_q      <= 1'b0;
            fault_q    <= 1'b0;
            flash_dw_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            req_q      <= req_d;
            fault_q    <= fault_d;
            flash_dw_q <= flash_dw_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        req_d      = req_q;
        fault_d    = fault_q | conflict;
        flash_dw_d = flash_dw_q;
        grant      = 1'b0;
        case (state_q)
            S_IDLE: begin
                sec_d      = '0;
                flash_dw_d = 1'b1;
                if (req_q && ped_red && !fault_q && !conflict) begin
                    grant   = 1'b1;
                    state_d = S_WALK;
                    sec_d   = CNT_W'(WALK_SEC);
                end
            end
            S_WALK: begin
                if (!ped_red) begin
                    state_d = S_IDLE;
                    sec_d   = '0;
                end else if (tick) begin
                    if (sec_q <= CNT_W'(1)) begin
                        state_d    = S_FLASH;
                        sec_d      = CNT_W'(FLASH_SEC);
                        flash_dw_d = 1'b1;
                    end else begin
                        sec_d = sec_q - 1'b1;
                    end
                end
            end
            S_FLASH: begin
                if (!ped_red) begin
                    state_d    = S_IDLE;
                    sec_d      = '0;
                    flash_dw_d = 1'b1;
                end else if (tick) begin
                    if (sec_q <= CNT_W'(1)) begin
                        state_d    = S_IDLE;
                        sec_d      = '0;
                        flash_dw_d = 1'b1;
                    end else begin
                        sec_d      = sec_q - 1'b1;
                        flash_dw_d = ~flash_dw_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                sec_d   = '0;
            end
        endcase
        // a conflict or latched fault parks the crossing regardless of timing
        if (fault_q || conflict) begin
            state_d = S_IDLE;
            sec_d   = '0;
        end
        if (grant) begin
            req_d = 1'b0;
        end
        if (btn_rise) begin
            req_d = 1'b1;
        end
    end

    assign walk        = (state_q == S_WALK) & ~fault_q;
    assign dont_walk   = fault_q | ~((state_q == S_WALK) | ((state_q == S_FLASH) & ~flash_dw_q));
    assign req_pending = req_q;
    assign fault       = fault_q;

`ifdef PED_COUNTDOWN_EN
    logic [CNT_W-1:0] cd_q, cd_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cd_q <= '0;
        end else begin
            cd_q <= cd_d;
        end
    end

    always_comb begin
        cd_d = '0;
        if (state_d == S_FLASH) begin
            cd_d = sec_d;
        end
    end

    assign countdown = cd_q;
`else
    assign countdown = '0;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb/tb_ped_crossing_ctrl.sv - scoreboard bench for ped_crossing_ctrl
module tb_ped_crossing_ctrl;

`ifdef PED_COUNTDOWN_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, tick, ped_btn;
    logic [2:0] light_1, light_2;
    logic       walk, dont_walk, req_pending, fault;
    logic [3:0] countdown;
    logic [7:0] obs;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [7:0] e;
    string      nm;

    ped_crossing_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .light_1     (light_1),
        .light_2     (light_2),
        .ped_btn     (ped_btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .req_pending (req_pending),
        .countdown   (countdown),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    assign obs = {walk, dont_walk, req_pending, countdown, fault};

    function automatic logic [7:0] pk(input logic w, input logic dw, input logic rq,
                                      input int cd, input logic f);
        logic [3:0] c;
        c = CD_EN ? cd[3:0] : 4'd0;
        return {w, dw, rq, c, f};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic press();
        ped_btn = 1'b1;
        cyc(8);
        ped_btn = 1'b0;
        cyc(8);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; ped_btn = 1'b0;
        light_1 = 3'b001; light_2 = 3'b100;
        cyc(2);
        exp_q.push_back(pk(0, 1, 0, 0, 0)); name_q.push_back("reset_state");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_bounce();
        ped_btn = 1'b1;
        cyc(3);
        ped_btn = 1'b0;
        cyc(10);
        exp_q.push_back(pk(0, 1, 0, 0, 0)); name_q.push_back("bounce_reject");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
        ped_btn = 1'b1;
        exp_q.push_back(pk(0, 1, 0, 0, 0)); name_q.push_back("btn_clk5");
        exp_q.push_back(pk(0, 1, 1, 0, 0)); name_q.push_back("btn_clk6");
        cyc(5);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
        cyc(1);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
        ped_btn = 1'b0;
        cyc(8);
    endtask

    task automatic test_wait_red();
        exp_q.push_back(pk(0, 1, 1, 0, 0)); name_q.push_back("wait_not_red");
        exp_q.push_back(pk(1, 0, 0, 0, 0)); name_q.push_back("grant_on_red");
        cyc(3);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
        light_1 = 3'b100; light_2 = 3'b001;
        cyc(1);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    endtask

    task automatic test_normal_cycle();
        for (int i = 1; i <= 13; i++) begin
            if (i < 7) begin
                exp_q.push_back(pk(1, 0, 0, 0, 0));
            end else if (i < 12) begin
                exp_q.push_back(pk(0, (i % 2) == 1, 0, 12 - i, 0));
            end else begin
                exp_q.push_back(pk(0, 1, 0, 0, 0));
            end
            name_q.push_back($sformatf("tick_%0d", i));
        end
        for (int i = 1; i <= 13; i++) begin
            cyc(2);
            do_tick();
            e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
        end
    endtask

    task automatic test_abort();
        press();
        exp_q.push_back(pk(1, 0, 0, 0, 0)); name_q.push_back("abort_pre_walk");
        exp_q.push_back(pk(0, 1, 0, 0, 0)); name_q.push_back("abort_idle");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
        do_tick();
        cyc(1);
        do_tick();
        light_1 = 3'b001; light_2 = 3'b100;
        do_tick();
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    endtask

    task automatic test_reset_mid_walk();
        light_1 = 3'b100; light_2 = 3'b001;
        press();
        exp_q.push_back(pk(1, 0, 0, 0, 0)); name_q.push_back("mid_walk");
        exp_q.push_back(pk(0, 1, 0, 0, 0)); name_q.push_back("async_reset");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
        #2 reset = 1'b1;
        #1;
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
        cyc(1);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_conflict();
        light_1 = 3'b001; light_2 = 3'b001;
        cyc(1);
        light_1 = 3'b100; light_2 = 3'b001;
        exp_q.push_back(pk(0, 1, 0, 0, 1)); name_q.push_back("fault_set");
        exp_q.push_back(pk(0, 1, 1, 0, 1)); name_q.push_back("fault_no_grant");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
        press();
        cyc(10);
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_wait_red();
        test_normal_cycle();
        test_abort();
        test_reset_mid_walk();
        test_conflict();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
